// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the radix-2 FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic en;
    logic bank;
  } wr_slot_t;

  localparam int LOG2N_DEF    = 5;
  localparam int BFLY_LAT_DEF = 3;
  localparam int STAGE_W      = 3;
  localparam int LAT_W        = 3;

  function automatic int n_half(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  localparam int N_HALF = n_half(LOG2N_DEF);

endpackage

// File: rtl/fft_stage_sequencer_wr_delay.sv
// fft_wr_delay: BFLY_LAT-deep shift line turning the read strobe and
// bank into the matching write strobe and (inverted) write bank.
module fft_wr_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = BFLY_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_en,
  input  logic rd_bank,
  output logic wr_en,
  output logic wr_bank
);

  wr_slot_t pipe [DEPTH];

  // Bank is stored pre-inverted and gated by the strobe, so an idle
  // line reads back as wr_bank=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{en: rd_en, bank: rd_en & ~rd_bank};
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign wr_en   = pipe[DEPTH-1].en;
  assign wr_bank = pipe[DEPTH-1].bank;

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: start/done FSM producing the radix-2 butterfly
// schedule. Optional ISSUE stall input enabled by FFT_SEQ_HOLD_EN.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEF,
  parameter int BFLY_LAT = BFLY_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef FFT_SEQ_HOLD_EN
  input  logic               hold,
`endif
  output logic [STAGE_W-1:0] stage,
  output logic [LOG2N-2:0]   bfly_idx,
  output logic [LOG2N-2:0]   tw_addr,
  output logic               rd_en,
  output logic               rd_bank,
  output logic               wr_en,
  output logic               wr_bank,
  output logic               busy,
  output logic               done,
  output logic               res_bank
);

  localparam int IW = LOG2N - 1;
  localparam logic [IW-1:0] LAST_IDX =
    IW'(n_half(LOG2N) - 1);
  localparam logic [STAGE_W-1:0] LAST_STG =
    STAGE_W'(LOG2N - 1);
  localparam logic [LAT_W-1:0] LAST_LAT =
    LAT_W'(BFLY_LAT - 1);
  localparam logic RES = 1'(LOG2N % 2);

  seq_state_t       state;
  logic             start_q;
  logic             launch;
  logic             stall;
  logic [LAT_W-1:0] lat_cnt;
  logic [IW-1:0]    idx_inc;

  // Keeps the top `s` index bits: stage s uses N/2^(s+1)-spaced twiddles.
  function automatic logic [IW-1:0] mask_of(
    input logic [STAGE_W-1:0] s
  );
    logic [IW-1:0] m;
    for (int b = 0; b < IW; b++) begin
      m[b] = (b >= IW - int'(s));
    end
    return m;
  endfunction

  assign launch  = start & ~start_q;
  assign idx_inc = bfly_idx + 1'b1;

`ifdef FFT_SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      stage    <= '0;
      bfly_idx <= '0;
      tw_addr  <= '0;
      rd_en    <= 1'b0;
      rd_bank  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lat_cnt  <= '0;
      res_bank <= RES;
    end else begin
      start_q  <= start;
      done     <= 1'b0;
      res_bank <= RES;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state    <= ISSUE;
            stage    <= '0;
            bfly_idx <= '0;
            tw_addr  <= '0;
            rd_bank  <= 1'b0;
            rd_en    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (stall) begin
            rd_en <= 1'b0;
          end else if (bfly_idx == LAST_IDX) begin
            state   <= DRAIN;
            rd_en   <= 1'b0;
            lat_cnt <= '0;
          end else begin
            rd_en    <= 1'b1;
            bfly_idx <= idx_inc;
            tw_addr  <= idx_inc & mask_of(stage);
          end
        end
        DRAIN: begin
          if (lat_cnt != LAST_LAT) begin
            lat_cnt <= lat_cnt + 1'b1;
          end else if (stage == LAST_STG) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ISSUE;
            stage    <= stage + 1'b1;
            rd_bank  <= ~rd_bank;
            bfly_idx <= '0;
            tw_addr  <= '0;
            rd_en    <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          stage    <= '0;
          bfly_idx <= '0;
          tw_addr  <= '0;
          rd_bank  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_wr_delay #(
    .DEPTH(BFLY_LAT)
  ) u_wr_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en  (rd_en),
    .rd_bank(rd_bank),
    .wr_en  (wr_en),
    .wr_bank(wr_bank)
  );

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench; expected read/write/done
// events are queued at launch and popped by a negedge monitor.
module tb_fft_stage_sequencer;

  localparam int L   = 5;
  localparam int LAT = 3;
  localparam int NH  = 1 << (L - 1);
  localparam int W   = L - 1;
  localparam int S   = NH + LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
  logic hold = 1'b0;
`endif
  logic [2:0]   stage;
  logic [W-1:0] bfly_idx;
  logic [W-1:0] tw_addr;
  logic rd_en, rd_bank, wr_en, wr_bank;
  logic busy, done, res_bank;

  fft_stage_sequencer #(
    .LOG2N   (L),
    .BFLY_LAT(LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef FFT_SEQ_HOLD_EN
    .hold    (hold),
`endif
    .stage   (stage),
    .bfly_idx(bfly_idx),
    .tw_addr (tw_addr),
    .rd_en   (rd_en),
    .rd_bank (rd_bank),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .busy    (busy),
    .done    (done),
    .res_bank(res_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int stg;
    int idx;
    int tw;
    int bank;
  } rd_ev_t;

  typedef struct {
    int cyc;
    int bank;
  } wr_ev_t;

  rd_ev_t rdq[$];
  wr_ev_t wrq[$];
  int     doneq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_lo = -1;
  int busy_hi = -2;
  int wr_seen = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               name, cyc, act, exp);
    end
  endtask

  // Schedule from first principles: stage k reads N/2 butterflies
  // starting at c+k*S; optional stall of hlen cycles after index hidx
  // of stage 0 shifts everything behind it.
  task automatic push_run(input int c, input int hidx, input int hlen);
    for (int k = 0; k < L; k++) begin
      for (int j = 0; j < NH; j++) begin
        int t;
        int tw;
        t  = c + k * S + j + ((k > 0 || j > hidx) ? hlen : 0);
        tw = (j >> (W - k)) << (W - k);
        rdq.push_back('{t, k, j, tw, k % 2});
        wrq.push_back('{t + LAT, 1 - (k % 2)});
      end
    end
    doneq.push_back(c + L * S + hlen);
    busy_lo = c;
    busy_hi = c + L * S + hlen - 1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_launch(input int hidx, input int hlen);
    start = 1'b1;
    push_run(cyc + 1, hidx, hlen);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_bfly_idx"}, int'(bfly_idx), 0);
    check({tag, "_tw_addr"}, int'(tw_addr), 0);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_bank"}, int'(rd_bank), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_bank"}, int'(wr_bank), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_res_bank"}, int'(res_bank), L % 2);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_rd_left"}, rdq.size(), 0);
    check({tag, "_wr_left"}, wrq.size(), 0);
    check({tag, "_done_left"}, doneq.size(), 0);
  endtask

  always @(negedge clk) begin
    rd_ev_t re;
    wr_ev_t we;
    int     de;
    if (rst_n) begin
      check("busy", int'(busy),
            int'(cyc >= busy_lo && cyc <= busy_hi));
      if (rd_en) begin
        if (rdq.size() == 0) begin
          check("rd_spurious", 1, 0);
        end else begin
          re = rdq.pop_front();
          check("rd_cycle", cyc, re.cyc);
          check("rd_stage", int'(stage), re.stg);
          check("rd_bfly_idx", int'(bfly_idx), re.idx);
          check("rd_tw_addr", int'(tw_addr), re.tw);
          check("rd_bank", int'(rd_bank), re.bank);
        end
      end
      if (wr_en) begin
        wr_seen++;
        if (wrq.size() == 0) begin
          check("wr_spurious", 1, 0);
        end else begin
          we = wrq.pop_front();
          check("wr_cycle", cyc, we.cyc);
          check("wr_bank", int'(wr_bank), we.bank);
        end
      end
      if (done) begin
        done_seen++;
        if (doneq.size() == 0) begin
          check("done_spurious", 1, 0);
        end else begin
          de = doneq.pop_front();
          check("done_cycle", cyc, de);
          check("res_bank", int'(res_bank), L % 2);
        end
      end
    end
  end

  initial begin
    int c0;
    int np;
    int wr0;
    int dn0;

    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    // Nominal run from a start pulse in cycle 10, plus ignored edges
    // while busy and in the DONE cycle itself.
    goto(10);
    pulse_launch(-1, 0);
    goto(50);
    start = 1'b1;
    goto(51);
    start = 1'b0;
    goto(106);
    start = 1'b1;
    goto(107);
    start = 1'b0;
    goto(115);
    check_drained("nominal");

    // Start held high across DONE, then a fresh edge relaunches.
    goto(120);
    start = 1'b1;
    push_run(121, -1, 0);
    goto(121 + L * S + 4);
    start = 1'b0;
    goto(cyc + 2);
    pulse_launch(-1, 0);
    goto(cyc + L * S + 4);
    check_drained("held");

    // Random back-to-back runs with stray edges while busy.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      c0 = cyc + 1;
      pulse_launch(-1, 0);
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        goto(c0 + p * 20 + $urandom_range(2, 18));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      goto(c0 + L * S + 1);
    end
    goto(cyc + 2);
    check_drained("random");

    // Asynchronous abort in the middle of stage 1.
    goto(cyc + 3);
    c0 = cyc + 1;
    pulse_launch(-1, 0);
    goto(c0 + 29);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    busy_lo = -1;
    busy_hi = -2;
    #1;
    check_reset("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr0 = wr_seen;
    dn0 = done_seen;
    goto(cyc + L * S + 10);
    check("abort_wr_after", wr_seen - wr0, 0);
    check("abort_done_after", done_seen - dn0, 0);

`ifdef FFT_SEQ_HOLD_EN
    // Four-cycle stall after index 7 of stage 0.
    c0 = cyc + 1;
    pulse_launch(7, 4);
    goto(c0 + 7);
    hold = 1'b1;
    goto(c0 + 9);
    check("hold_bfly_idx", int'(bfly_idx), 7);
    check("hold_rd_en", int'(rd_en), 0);
    goto(c0 + 11);
    hold = 1'b0;
    goto(c0 + L * S + 8);
    check_drained("hold");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Top-level sequencing FSM for the radix-2 FFT core. It turns a start request into the full stage-by-stage butterfly schedule: current stage, butterfly index, twiddle address, read/write enables and ping-pong bank selects. Write enables are delayed to match the butterfly pipeline, and each stage is drained before the next begins. It sits between the host start/done handshake and the address-generation/memory datapath.

## Interface
- LOG2N, default 5: log2 of FFT size N; stages = LOG2N, butterflies per stage = N/2.
- BFLY_LAT, default 3: butterfly pipeline latency in cycles, read to write; legal range 1..7.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level input; a rising edge sampled in IDLE launches a transform.
- stage  out  3  current stage index i, 0..LOG2N-1.
- bfly_idx  out  LOG2N-1  butterfly index j within the stage.
- tw_addr  out  LOG2N-1  twiddle address = bfly_idx & mask; mask has its top `stage` bits set (stage 0 → 0).
- rd_en  out  1  butterfly operand read issued this cycle.
- rd_bank  out  1  bank read this stage; 0 at stage 0, toggles per stage.
- wr_en  out  1  rd_en delayed BFLY_LAT cycles.
- wr_bank  out  1  rd_bank delayed BFLY_LAT cycles, inverted.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse when the transform completes.
- res_bank  out  1  bank holding the final result; equals LOG2N[0]; valid when done is high.

## Operation
- States:
  - IDLE → ISSUE on a start rising edge (start=1 now, 0 on the previous clk; the edge register updates every cycle).
  - ISSUE: rd_en=1, bfly_idx increments each cycle. At bfly_idx = N/2-1 → DRAIN.
  - DRAIN: rd_en=0 for exactly BFLY_LAT cycles. Then, if stage = LOG2N-1 → DONE; otherwise stage++, rd_bank toggles, bfly_idx=0, → ISSUE.
  - DONE: done=1, busy=0, one cycle → IDLE.
- Start edges outside IDLE are ignored. start held high across DONE does not relaunch; a new low→high transition is required.
- The wr_en/wr_bank delay line shifts every cycle in every state, so all BFLY_LAT trailing writes of a stage land inside its DRAIN.
- Reset values: stage=0, bfly_idx=0, tw_addr=0, rd_en=0, wr_en=0, rd_bank=0, wr_bank=0, busy=0, done=0, res_bank=LOG2N[0]. The delay line is cleared.
- Reset mid-transform aborts immediately: all outputs go to reset values, no done pulse, and no pending writes are issued.

## Timing
- Start edge sampled at cycle t → first rd_en at t+1 (cycle c).
- Stage k, with S = N/2 + BFLY_LAT:
  - rd_en over c+k·S .. c+k·S+N/2-1.
  - wr_en over the same window shifted by BFLY_LAT.
- done at c + LOG2N·S. With defaults: 5·(16+3)=95, so done at c+95.
- busy is high c .. c+LOG2N·S-1. A new start edge is accepted from c+LOG2N·S+1.
- All outputs are registered; no combinational path from start.

## Configuration
- FFT_SEQ_HOLD_EN defined: adds input port `hold` (1 bit).
  - hold=1 in ISSUE: rd_en=0, bfly_idx and tw_addr frozen, state unchanged.
  - The delay line keeps shifting, so in-flight writes complete.
  - hold is ignored in IDLE, DRAIN and DONE.
  - Each held cycle extends the schedule by one cycle.
- Undefined: no `hold` port; ISSUE never stalls.

## Structure
- Shared package fft_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), default LOG2N, N_HALF = 1<<(LOG2N-1), stage width constant.
- One sub-module, fft_wr_delay: a BFLY_LAT-deep, 2-bit-wide shift register {rd_en, rd_bank} → {wr_en, ~wr_bank source}, cleared by rst_n.
- Mask generation and twiddle AND stay inline.

## Test plan
- Defaults, start pulse at t=10 → rd_en cycles 11..26, wr_en 14..29, stage=1 at cycle 30, done exactly at cycle 106, res_bank=1.
- Stage 3 → tw_addr observed for bfly_idx=4'b1011 equals 4'b1010; stage 0 → tw_addr=0 throughout.
- start held high through DONE → exactly one done; toggling start low then high in IDLE → second run with identical schedule.
- rst_n dropped at cycle 40 mid-stage-1 → all outputs 0 (res_bank=1) asynchronously, wr_en stays low afterwards, no done.
- Start edge during busy (cycle 50) → ignored; done timing unchanged.
- FFT_SEQ_HOLD_EN, hold=1 for 4 cycles at bfly_idx=7 of stage 0 → rd_en gap of 4, bfly_idx stays 7, done delayed to cycle 110.
